// File: rtl/mmio_timer_slot.sv
// mmio_timer_slot: slot-0 responder on the MMIO controller's slot bus, holding
// a 64-bit free-running timer with prescaler, 64-bit compare, match flag and
// level interrupt.
//
// Ports:
//   aclk, arst_n           clock, asynchronous active-low reset
//   chip_select            slot select from the controller
//   read, write            request strobes, qualified by chip_select
//   reg_addr[7:0]          register byte offset
//   wr_data[31:0]          write data, valid the cycle after the cs&write cycle
//   transaction_completed  controller has closed its response phase
//   rd_data[31:0]          read data, held through the response phase
//   wr_done, rd_done       transaction complete flags
//   idle                   responder is in IDLE
//   slave_error            write to a read-only register
//   decode_error           unmapped or misaligned offset
//   signal_received        one-cycle pulse when a request is accepted
//   irq                    match_flag & irq_en
module mmio_timer_slot #(
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        chip_select,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] wr_data,
    input  logic        transaction_completed,
    output logic [31:0] rd_data,
    output logic        wr_done,
    output logic        rd_done,
    output logic        idle,
    output logic        slave_error,
    output logic        decode_error,
    output logic        signal_received,
    output logic        irq
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 64;

    localparam logic [ADDR_W-1:0] A_CTRL     = 8'h00;
    localparam logic [ADDR_W-1:0] A_STATUS   = 8'h04;
    localparam logic [ADDR_W-1:0] A_COUNT_LO = 8'h08;
    localparam logic [ADDR_W-1:0] A_COUNT_HI = 8'h0C;
    localparam logic [ADDR_W-1:0] A_CMP_LO   = 8'h10;
    localparam logic [ADDR_W-1:0] A_CMP_HI   = 8'h14;
    localparam logic [ADDR_W-1:0] A_PRESCALE = 8'h18;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WR_CAP = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Address decode helpers
    function automatic logic f_mapped(input logic [ADDR_W-1:0] a);
        case (a)
            A_CTRL, A_STATUS, A_COUNT_LO, A_COUNT_HI,
            A_CMP_LO, A_CMP_HI, A_PRESCALE: f_mapped = 1'b1;
            default:                        f_mapped = 1'b0;
        endcase
    endfunction

    function automatic logic f_ro(input logic [ADDR_W-1:0] a);
        f_ro = (a == A_COUNT_LO) || (a == A_COUNT_HI);
    endfunction

    // Bus-side registers
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_wr_done;
    logic                r_rd_done;
    logic                r_idle;
    logic                r_slv_err;
    logic                r_dec_err;
    logic                r_sig_rx;
    logic                r_irq;

    // Timer registers
    logic                r_en;
    logic                r_irq_en;
    logic                r_auto;
    logic                r_match;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_cmp;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [DATA_W-1:0]   r_snap;

    // Next-state / next-output wires
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_rd_data_nxt;
    logic                w_wr_done_nxt;
    logic                w_rd_done_nxt;
    logic                w_slv_err_nxt;
    logic                w_dec_err_nxt;
    logic                w_sig_rx_nxt;
    logic                w_rd_acc;
    logic [DATA_W-1:0]   w_rd_val;

    // Timer control wires
    logic                w_wr_ok;
    logic                w_wr_ctrl;
    logic                w_clr;
    logic                w_tick;
    logic                w_hit;
    logic                w_w1c;
    logic                w_match_nxt;
    logic                w_irq_en_nxt;

    // Register read mux on the live request address
    always_comb begin
        w_rd_val = '0;
        case (reg_addr)
            A_CTRL:     w_rd_val = {28'd0, r_auto, r_irq_en, 1'b0, r_en};
            A_STATUS:   w_rd_val = {31'd0, r_match};
            A_COUNT_LO: w_rd_val = r_count[31:0];
            A_COUNT_HI: w_rd_val = r_snap;
            A_CMP_LO:   w_rd_val = r_cmp[31:0];
            A_CMP_HI:   w_rd_val = r_cmp[63:32];
            A_PRESCALE: w_rd_val = DATA_W'(r_prescale);
            default:    w_rd_val = '0;
        endcase
    end

    // Responder FSM: next state and next registered outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_rd_data_nxt = r_rd_data;
        w_wr_done_nxt = r_wr_done;
        w_rd_done_nxt = r_rd_done;
        w_slv_err_nxt = r_slv_err;
        w_dec_err_nxt = r_dec_err;
        w_sig_rx_nxt  = 1'b0;
        w_rd_acc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // write takes priority when both strobes are high
                if (chip_select && write) begin
                    w_sig_rx_nxt = 1'b1;
                    w_addr_nxt   = reg_addr;
                    w_state_nxt  = S_WR_CAP;
                end else if (chip_select && read) begin
                    w_sig_rx_nxt  = 1'b1;
                    w_addr_nxt    = reg_addr;
                    w_rd_acc      = 1'b1;
                    w_rd_data_nxt = f_mapped(reg_addr) ? w_rd_val : '0;
                    w_rd_done_nxt = 1'b1;
                    w_dec_err_nxt = !f_mapped(reg_addr);
                    w_state_nxt   = S_RESP;
                end
            end
            S_WR_CAP: begin
                w_wr_done_nxt = 1'b1;
                w_slv_err_nxt = f_mapped(r_addr) && f_ro(r_addr);
                w_dec_err_nxt = !f_mapped(r_addr);
                w_state_nxt   = S_RESP;
            end
            S_RESP: begin
                if (!chip_select && transaction_completed) begin
                    w_wr_done_nxt = 1'b0;
                    w_rd_done_nxt = 1'b0;
                    w_slv_err_nxt = 1'b0;
                    w_dec_err_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered bus outputs
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_rd_data <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_idle    <= 1'b1;
            r_slv_err <= 1'b0;
            r_dec_err <= 1'b0;
            r_sig_rx  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_rd_done <= w_rd_done_nxt;
            r_idle    <= (w_state_nxt == S_IDLE);
            r_slv_err <= w_slv_err_nxt;
            r_dec_err <= w_dec_err_nxt;
            r_sig_rx  <= w_sig_rx_nxt;
        end
    end

    // Register write commit happens at the edge that ends WR_CAP
    assign w_wr_ok   = (r_state == S_WR_CAP) && f_mapped(r_addr) && !f_ro(r_addr);
    assign w_wr_ctrl = w_wr_ok && (r_addr == A_CTRL);
    assign w_clr     = w_wr_ctrl && wr_data[1];
    assign w_tick    = r_en && (r_pcnt == r_prescale);
    // a clear write suppresses the tick, including its compare
    assign w_hit     = w_tick && !w_clr && (r_count == r_cmp);
    assign w_w1c     = w_wr_ok && (r_addr == A_STATUS) && wr_data[0];
    // a match set in the same cycle as a W1C wins
    assign w_match_nxt  = w_hit || (r_match && !w_w1c);
    assign w_irq_en_nxt = w_wr_ctrl ? wr_data[2] : r_irq_en;

    // Timer, control and compare registers
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_auto     <= 1'b0;
            r_match    <= 1'b0;
            r_count    <= '0;
            r_cmp      <= CMP_RESET;
            r_pcnt     <= '0;
            r_prescale <= '0;
            r_snap     <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_clr) begin
                r_count <= '0;
                r_pcnt  <= '0;
            end else if (w_tick) begin
                r_count <= (w_hit && r_auto) ? '0 : r_count + CNT_W'(1);
                r_pcnt  <= '0;
            end else if (r_en) begin
                r_pcnt  <= r_pcnt + PRESCALE_W'(1);
            end

            r_match  <= w_match_nxt;
            r_irq_en <= w_irq_en_nxt;
            // irq tracks match & irq_en with no extra cycle of delay
            r_irq    <= w_match_nxt && w_irq_en_nxt;

            if (w_wr_ctrl) begin
                r_en   <= wr_data[0];
                r_auto <= wr_data[3];
            end
            if (w_wr_ok && (r_addr == A_CMP_LO))   r_cmp[31:0]  <= wr_data;
            if (w_wr_ok && (r_addr == A_CMP_HI))   r_cmp[63:32] <= wr_data;
            if (w_wr_ok && (r_addr == A_PRESCALE)) r_prescale   <= wr_data[PRESCALE_W-1:0];

            // COUNT_LO read freezes the upper half for a following COUNT_HI read
            if (w_rd_acc && (reg_addr == A_COUNT_LO)) r_snap <= r_count[63:32];
        end
    end

    assign rd_data         = r_rd_data;
    assign wr_done         = r_wr_done;
    assign rd_done         = r_rd_done;
    assign idle            = r_idle;
    assign slave_error     = r_slv_err;
    assign decode_error    = r_dec_err;
    assign signal_received = r_sig_rx;
    assign irq             = r_irq;

endmodule

// File: tb/tb_mmio_timer_slot.sv
// tb_mmio_timer_slot: randomized bus traffic against mmio_timer_slot, checked
// against a register-level model of the timer kept in the bench.
module tb_mmio_timer_slot;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic        chip_select = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  reg_addr = '0;
    logic [31:0] wr_data = '0;
    logic        transaction_completed = 1'b0;
    logic [31:0] rd_data;
    logic        wr_done, rd_done, idle, slave_error, decode_error, signal_received, irq;

    always #5 aclk = ~aclk;

    mmio_timer_slot dut (
        .aclk(aclk), .arst_n(arst_n), .chip_select(chip_select), .read(read),
        .write(write), .reg_addr(reg_addr), .wr_data(wr_data),
        .transaction_completed(transaction_completed), .rd_data(rd_data),
        .wr_done(wr_done), .rd_done(rd_done), .idle(idle), .slave_error(slave_error),
        .decode_error(decode_error), .signal_received(signal_received), .irq(irq)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_commit_cyc = 0;
    logic irq_at_commit;

    // Register-level model state
    bit          m_en, m_irq_en, m_auto, m_match;
    logic [63:0] m_count, m_cmp;
    logic [15:0] m_pcnt, m_pre;
    logic [31:0] m_snap, m_rval, m_rdhold;
    bit          m_commit, m_racc;
    logic [7:0]  m_caddr, m_raddr;
    logic [31:0] m_cdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_range(input string name, input logic [63:0] act, input logic [63:0] lo, input logic [63:0] hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic bit m_mapped(input logic [7:0] a);
        return a == 8'h00 || a == 8'h04 || a == 8'h08 || a == 8'h0C ||
               a == 8'h10 || a == 8'h14 || a == 8'h18;
    endfunction

    function automatic bit m_ro(input logic [7:0] a);
        return a == 8'h08 || a == 8'h0C;
    endfunction

    function automatic logic [31:0] m_regval(input logic [7:0] a);
        case (a)
            8'h00: return {28'd0, m_auto, m_irq_en, 1'b0, m_en};
            8'h04: return {31'd0, m_match};
            8'h08: return m_count[31:0];
            8'h0C: return m_snap;
            8'h10: return m_cmp[31:0];
            8'h14: return m_cmp[63:32];
            8'h18: return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_reset();
        m_en = 0; m_irq_en = 0; m_auto = 0; m_match = 0;
        m_count = '0; m_cmp = '1; m_pcnt = '0; m_pre = '0;
        m_snap = '0; m_rval = '0; m_rdhold = '0;
        m_commit = 0; m_racc = 0; m_caddr = '0; m_raddr = '0; m_cdata = '0;
    endfunction

    // One clock edge of the timer, from the pre-edge model state
    function automatic void model_edge();
        bit wok, clr, tick, hit;
        wok = m_commit && m_mapped(m_caddr) && !m_ro(m_caddr);
        if (m_racc) begin
            m_rval = m_mapped(m_raddr) ? m_regval(m_raddr) : 32'd0;
            if (m_raddr == 8'h08) m_snap = m_count[63:32];
        end
        clr  = wok && m_caddr == 8'h00 && m_cdata[1];
        tick = m_en && (m_pcnt == m_pre);
        hit  = tick && !clr && (m_count == m_cmp);
        if (clr) begin
            m_count = '0; m_pcnt = '0;
        end else if (tick) begin
            m_count = (hit && m_auto) ? 64'd0 : m_count + 64'd1;
            m_pcnt = '0;
        end else if (m_en) begin
            m_pcnt = m_pcnt + 16'd1;
        end
        if (hit) m_match = 1;
        else if (wok && m_caddr == 8'h04 && m_cdata[0]) m_match = 0;
        if (wok) begin
            case (m_caddr)
                8'h00: begin m_en = m_cdata[0]; m_irq_en = m_cdata[2]; m_auto = m_cdata[3]; end
                8'h10: m_cmp[31:0] = m_cdata;
                8'h14: m_cmp[63:32] = m_cdata;
                8'h18: m_pre = m_cdata[15:0];
                default: ;
            endcase
        end
    endfunction

    // Advance one cycle; irq is compared against the model every cycle
    task automatic step();
        @(posedge aclk);
        model_edge();
        cyc++;
        @(negedge aclk);
        chk("irq", irq, m_match & m_irq_en);
    endtask

    task automatic gap(input int n);
        chip_select = 0; transaction_completed = 0;
        for (int i = 0; i < n; i++) begin
            read = 1'($urandom); write = 1'($urandom);
            step();
            chk("gap_idle", idle, 1);
            chk("gap_sigrx", signal_received, 0);
        end
        read = 0; write = 0;
    endtask

    task automatic finish_resp(input int hold, input bit e_wr, input bit e_rd, input bit e_slv, input bit e_dec);
        for (int i = 0; i < hold; i++) begin
            int unsigned k;
            k = $urandom_range(0, 2);
            chip_select = (k != 1);
            transaction_completed = (k == 0);
            read = 1'($urandom); write = 1'($urandom); reg_addr = 8'($urandom);
            step();
            chk("hold_wr_done", wr_done, e_wr);
            chk("hold_rd_done", rd_done, e_rd);
            chk("hold_slv_err", slave_error, e_slv);
            chk("hold_dec_err", decode_error, e_dec);
            chk("hold_rd_data", rd_data, m_rdhold);
            chk("hold_idle", idle, 0);
            chk("hold_sigrx", signal_received, 0);
        end
        chip_select = 0; read = 0; write = 0; transaction_completed = 1;
        step();
        chk("close_idle", idle, 1);
        chk("close_wr_done", wr_done, 0);
        chk("close_rd_done", rd_done, 0);
        chk("close_slv_err", slave_error, 0);
        chk("close_dec_err", decode_error, 0);
        transaction_completed = 0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int hold);
        bit e_slv, e_dec;
        e_slv = m_mapped(a) && m_ro(a);
        e_dec = !m_mapped(a);
        chk("wr_idle_before", idle, 1);
        chip_select = 1; write = 1; read = 1'($urandom); reg_addr = a;
        step();
        chk("wr_sigrx", signal_received, 1);
        chk("wr_busy", idle, 0);
        chk("wr_done_early", wr_done, 0);
        // chip_select is don't-care while the data is captured
        wr_data = d; chip_select = 1'($urandom); write = 0; read = 0; reg_addr = 8'($urandom);
        m_commit = 1; m_caddr = a; m_cdata = d;
        step();
        m_commit = 0;
        last_commit_cyc = cyc;
        irq_at_commit = irq;
        chk("wr_done", wr_done, 1);
        chk("wr_slv_err", slave_error, e_slv);
        chk("wr_dec_err", decode_error, e_dec);
        chk("wr_rd_done", rd_done, 0);
        chk("wr_sigrx_pulse", signal_received, 0);
        wr_data = $urandom;
        finish_resp(hold, 1, 0, e_slv, e_dec);
    endtask

    task automatic do_read(input logic [7:0] a, input int hold, output logic [31:0] val);
        bit e_dec;
        e_dec = !m_mapped(a);
        chk("rd_idle_before", idle, 1);
        chip_select = 1; read = 1; write = 0; reg_addr = a;
        m_racc = 1; m_raddr = a;
        step();
        m_racc = 0;
        chk("rd_done", rd_done, 1);
        chk("rd_data", rd_data, m_rval);
        chk("rd_dec_err", decode_error, e_dec);
        chk("rd_slv_err", slave_error, 0);
        chk("rd_sigrx", signal_received, 1);
        chk("rd_wr_done", wr_done, 0);
        chk("rd_busy", idle, 0);
        m_rdhold = m_rval;
        val = rd_data;
        finish_resp(hold, 0, 1, 0, e_dec);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_wr_done"}, wr_done, 0);
        chk({tag, "_rd_done"}, rd_done, 0);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_slv_err"}, slave_error, 0);
        chk({tag, "_dec_err"}, decode_error, 0);
        chk({tag, "_sigrx"}, signal_received, 0);
        chk({tag, "_irq"}, irq, 0);
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  pool [8];
        logic [7:0]  a;
        logic [31:0] d;
        int          delta;
        bit          seen;
        pool = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};

        // Reset
        model_reset();
        repeat (2) @(negedge aclk);
        chk_reset_outputs("rst");
        arst_n = 1;
        gap(2);

        // Compare register reset value
        do_read(8'h10, 0, v); chk("cmp_lo_reset", v, 32'hFFFF_FFFF);
        do_read(8'h14, 1, v); chk("cmp_hi_reset", v, 32'hFFFF_FFFF);

        // Prescaled counting
        do_write(8'h18, 32'd3, 0);
        do_write(8'h00, 32'h1, 0);
        gap(40);
        do_read(8'h08, 0, v); chk_range("count_lo_prescaled", v, 9, 11);
        do_read(8'h0C, 0, v); chk("count_hi_snap", v, 0);
        do_write(8'h08, 32'h1234_5678, 2);
        do_read(8'h08, 0, v);

        // Compare match, auto-reload and interrupt
        do_write(8'h00, 32'h2, 0);
        do_write(8'h18, 32'd0, 0);
        do_write(8'h10, 32'd5, 0);
        do_write(8'h14, 32'd0, 0);
        do_write(8'h04, 32'h1, 0);
        do_write(8'h00, 32'hD, 0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (irq) seen = 1; else gap(1);
        end
        delta = cyc - last_commit_cyc;
        chk("irq_seen", seen, 1);
        chk("match_latency", delta, 6);
        do_write(8'h00, 32'h4, 0);
        do_read(8'h04, 0, v); chk("status_match", v, 1);
        chk("irq_high", irq, 1);
        do_write(8'h04, 32'h1, 0);
        chk("irq_drop_n2", irq_at_commit, 0);

        // Decode errors
        do_read(8'h1C, 3, v); chk("dec_1c_data", v, 0);
        do_read(8'h05, 2, v); chk("dec_05_data", v, 0);
        do_write(8'h20, 32'hDEAD_BEEF, 1);

        // Count wrap and clear racing a tick
        do_write(8'h00, 32'h0, 0);
        do_write(8'h18, 32'd0, 0);
        force dut.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_count;
        m_count = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(8'h00, 32'h1, 0);
        do_read(8'h08, 0, v); chk_range("wrap_lo", v, 0, 9);
        do_read(8'h0C, 0, v); chk("wrap_hi", v, 0);
        do_write(8'h00, 32'h2, 0);
        do_read(8'h08, 0, v); chk("clear_beats_tick", v, 0);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            a = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) a = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                case (a)
                    8'h00: begin d = 32'($urandom_range(0, 15)); d[1] = ($urandom_range(0, 7) == 0); end
                    8'h10: d = 32'($urandom_range(0, 40));
                    8'h14: d = ($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0;
                    8'h18: d = 32'($urandom_range(0, 3));
                    default: d = $urandom;
                endcase
                do_write(a, d, $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, 3), v);
            end
            gap($urandom_range(0, 4));
        end

        // Reset during WR_CAP of a CMP_LO write
        chip_select = 1; write = 1; read = 0; reg_addr = 8'h10;
        step();
        wr_data = 32'h0000_0042; chip_select = 0; write = 0;
        #2 arst_n = 0;
        #1 chk_reset_outputs("arst_async");
        model_reset();
        @(negedge aclk);
        chk_reset_outputs("arst_held");
        arst_n = 1;
        gap(1);
        do_read(8'h10, 0, v); chk("cmp_lo_after_abort", v, 32'hFFFF_FFFF);
        do_read(8'h00, 0, v); chk("ctrl_after_abort", v, 0);
        do_read(8'h08, 0, v); chk("count_after_abort", v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_timer_slot.md
Name: mmio_timer_slot

Overview:
- Slot-side responder for the MMIO controller's 16-slot bus; intended for slot 0 (timer).
- Decodes chip_select/read/write/reg_addr and returns rd_data, done, idle and error flags using the handshake the controller expects.
- Contains a 64-bit free-running timer with prescaler, 64-bit compare, match flag and level interrupt.

Parameters:
PRESCALE_W, 16, width of prescaler reload register and prescale counter
CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of compare register

Ports:
aclk  in  1  clock
arst_n  in  1  asynchronous active-low reset
chip_select  in  1  slot select from controller
read  in  1  read strobe (qualified by chip_select)
write  in  1  write strobe (qualified by chip_select)
reg_addr  in  8  byte offset of register
wr_data  in  32  write data (registered in controller, valid one cycle after first cs&write)
transaction_completed  in  1  controller has closed the AXI response phase
rd_data  out  32  read data, held through response phase
wr_done  out  1  write completed
rd_done  out  1  read data valid
idle  out  1  responder in IDLE
slave_error  out  1  write to read-only register
decode_error  out  1  unmapped or misaligned offset
signal_received  out  1  one-cycle pulse on request acceptance
irq  out  1  match_flag & irq_en

Behaviour:
- Reset is asynchronous and active-low on arst_n; clock is aclk.
- Reset values: FSM IDLE, rd_data 0, wr_done/rd_done/errors/signal_received/irq 0, idle 1, CTRL 0, STATUS 0, count 0, prescale counter 0, PRESCALE 0, CMP CMP_RESET, hi-snapshot 0.
- Reset asserted mid-transaction aborts it. No partial register update. FSM returns to IDLE.
- Register map (byte offsets; reg_addr[1:0]!=0 -> decode_error):
  0x00 CTRL RW: [0] enable, [1] clear (self-clearing, reads 0), [2] irq_en, [3] auto_reload.
  0x04 STATUS: [0] match_flag, write-1-to-clear.
  0x08 COUNT_LO RO; a read latches count[63:32] into hi-snapshot.
  0x0C COUNT_HI RO; returns hi-snapshot.
  0x10 CMP_LO RW.
  0x14 CMP_HI RW.
  0x18 PRESCALE RW [PRESCALE_W-1:0], upper bits read 0.
  Any other offset -> decode_error.
- FSM IDLE -> WR_CAP -> RESP, or IDLE -> RESP (read):
  IDLE: idle=1. On chip_select&write, pulse signal_received, latch reg_addr, go to WR_CAP. Write wins if read and write are both high. On chip_select&read, pulse signal_received, latch reg_addr, load rd_data with the register value (or 0 on error), set rd_done and the error flag, and go to RESP.
  WR_CAP: sample wr_data and perform the write at the edge ending this cycle. Set wr_done and the error flag, then go to RESP. A write to a RO or unmapped register makes no update. chip_select is ignored in this state.
  RESP: hold done, errors and rd_data stable. When chip_select==0 && transaction_completed==1, clear done/errors and go to IDLE on the next edge. New requests are ignored until IDLE.
- Latency from the first cs&req cycle N: read rd_done high at N+1; write wr_done high at N+2, register value visible at N+2.
- Timer tick: enabled when CTRL.enable=1. The prescale counter counts 0..PRESCALE; tick is asserted when it equals PRESCALE, then it reloads 0. PRESCALE=0 gives a tick every cycle.
- On tick: if count==CMP, set match_flag. If auto_reload is also set, count goes to 0, else count+1. Count wraps from 2^64-1 to 0 silently.
- Clear write (CTRL[1]=1) zeroes count and the prescale counter at the same edge and overrides a tick.
- STATUS W1C in the same cycle as a match set: set wins.
- irq is registered-equivalent: irq = match_flag & irq_en. It stays high until match_flag is cleared or irq_en drops.
- CMP writes take effect for comparisons from the next cycle.

Test Plan:
- Reset, then read 0x10 and 0x14 -> rd_done at N+1, rd_data 0xFFFF_FFFF both, no errors. idle=1 before and after, signal_received pulses once.
- Write PRESCALE=3, CTRL=0x1, wait 40 cycles, read COUNT_LO then COUNT_HI -> COUNT_LO ≈ 10 (±1), COUNT_HI 0. Also confirm that a count write at 0x08 gives slave_error=1 with wr_done=1 and count unchanged.
- CMP=5, CTRL=0xD (enable, irq_en, auto_reload), PRESCALE=0 -> match_flag and irq set 6 cycles after enable, count returns to 0. Write STATUS=1 -> irq drops at N+2.
- Read 0x1C and 0x05 -> decode_error=1, rd_data 0. Done and error are held until cs=0 and transaction_completed=1, then idle=1 the next cycle.
- Force count to 0xFFFF_FFFF_FFFF_FFFF via the backdoor and tick -> count 0, no error. Write CTRL clear on the same cycle as a tick -> count 0, not 1.
- Assert arst_n low during WR_CAP of a CMP_LO write -> CMP stays CMP_RESET, FSM IDLE, all outputs at reset values.
